control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 39 +++
 rtl/control_unit_decoder.sv | 34 +++
 rtl/control_unit.sv | 97 +++++++++
 tb/tb_control_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared opcode constants, FSM state encodings and the control-word struct
// for the single-cycle controller and its datapath bench.
package control_unit_pkg;

  localparam logic [5:0] OP_J   = 6'b000100;
  localparam logic [5:0] OP_JZ  = 6'b000101;
  localparam logic [5:0] OP_JNZ = 6'b000110;
  localparam logic [5:0] OP_IN  = 6'b000111;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_IOWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       s_datos;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
    logic       stall;
    logic       io_req;
  } ctrl_t;

  // Safe "hold everything" word: PC frozen, no writes, no peripheral request.
  localparam ctrl_t CTRL_HOLD = '{
    s_inc:   1'b1,
    s_inm:   1'b0,
    s_datos: 1'b0,
    we3:     1'b0,
    wez:     1'b0,
    op_alu:  3'b000,
    stall:   1'b1,
    io_req:  1'b0
  };

endpackage

// File: rtl/control_unit_decoder.sv
// Purely combinational opcode-to-control decode for the RUN state.
// IN is flagged so the FSM can start the peripheral handshake.
module control_unit_decoder
  import control_unit_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic       i_z,
  output ctrl_t      o_ctrl,
  output logic       o_is_in
);

  always_comb begin
    o_ctrl       = CTRL_HOLD;
    o_ctrl.stall = 1'b0;
    o_is_in      = 1'b0;
    case (i_opcode)
      OP_J:   o_ctrl.s_inc = 1'b0;
      OP_JZ:  o_ctrl.s_inc = ~i_z;
      OP_JNZ: o_ctrl.s_inc = i_z;
      OP_IN: begin
        o_is_in       = 1'b1;
        o_ctrl.stall  = 1'b1;
        o_ctrl.io_req = 1'b1;
      end
      default: begin
        o_ctrl.s_inm  = i_opcode[5];
        o_ctrl.op_alu = i_opcode[4:2];
        o_ctrl.we3    = 1'b1;
        o_ctrl.wez    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Controller FSM (BOOT/RUN/IOWAIT) with Mealy outputs, input-wait counter
// and sticky io_err; opcode decode lives in control_unit_decoder.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int IO_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       io_ready,
  output logic       s_inc,
  output logic       s_inm,
  output logic       s_datos,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu,
  output logic       stall,
  output logic       io_req,
  output logic       io_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(IO_TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic       r_io_err;
  ctrl_t      w_dec;
  ctrl_t      w_ctrl;
  logic       w_dec_is_in;
  logic       w_timeout;

  control_unit_decoder u_decoder (
    .i_opcode (opcode),
    .i_z      (z),
    .o_ctrl   (w_dec),
    .o_is_in  (w_dec_is_in)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = CTRL_HOLD;
    w_timeout   = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_ctrl = w_dec;
        if (w_dec_is_in) w_state_nxt = ST_IOWAIT;
      end
      ST_IOWAIT: begin
        w_ctrl.io_req = 1'b1;
        // Data arriving in the timeout cycle still wins over the abort.
        if (io_ready) begin
          w_ctrl.s_datos = 1'b1;
          w_ctrl.we3     = 1'b1;
          w_ctrl.stall   = 1'b0;
          w_state_nxt    = ST_RUN;
        end else if (r_wait_cnt == TIMEOUT_CNT) begin
          w_ctrl.stall = 1'b0;
          w_timeout    = 1'b1;
          w_state_nxt  = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Counter holds completed wait cycles; it is zero on every IOWAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
      r_io_err   <= 1'b0;
    end else begin
      if (r_state != ST_IOWAIT) r_wait_cnt <= 8'd0;
      else                      r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout) r_io_err <= 1'b1;
    end
  end

  assign s_inc   = w_ctrl.s_inc;
  assign s_inm   = w_ctrl.s_inm;
  assign s_datos = w_ctrl.s_datos;
  assign we3     = w_ctrl.we3;
  assign wez     = w_ctrl.wez;
  assign op_alu  = w_ctrl.op_alu;
  assign stall   = w_ctrl.stall;
  assign io_req  = w_ctrl.io_req;
  assign io_err  = r_io_err;

endmodule

// File: tb/tb_control_unit.sv
// Directed plus randomized bench for control_unit with a cycle-level
// reference model of the controller's rules.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       s_datos;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
    logic       stall;
    logic       io_req;
    logic       io_err;
  } outv_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode;
  logic       z;
  logic       io_ready;
  logic       s_inc, s_inm, s_datos, we3, wez, stall, io_req, io_err;
  logic [2:0] op_alu;
  outv_t      dut_v;

  int vectors = 0;
  int miscompares = 0;

  // Model state: booting flag, IOWAIT cycles already waited (-1 = not waiting), sticky error
  bit m_boot;
  int m_wait;
  bit m_err;

  always #5 clk = ~clk;

  control_unit #(.IO_TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .z        (z),
    .io_ready (io_ready),
    .s_inc    (s_inc),
    .s_inm    (s_inm),
    .s_datos  (s_datos),
    .we3      (we3),
    .wez      (wez),
    .op_alu   (op_alu),
    .stall    (stall),
    .io_req   (io_req),
    .io_err   (io_err)
  );

  assign dut_v = {s_inc, s_inm, s_datos, we3, wez, op_alu, stall, io_req, io_err};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_boot <= 1'b1;
      m_wait <= -1;
      m_err  <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (m_wait >= 0) begin
      if (io_ready)         m_wait <= -1;
      else if (m_wait == TO) begin
        m_wait <= -1;
        m_err  <= 1'b1;
      end else              m_wait <= m_wait + 1;
    end else if (opcode == OP_IN) begin
      m_wait <= 0;
    end
  end

  function automatic outv_t model_out(input logic [5:0] op, input logic zz, input logic rdy);
    outv_t e;
    e = '0;
    e.s_inc  = 1'b1;
    e.stall  = 1'b1;
    e.io_err = m_err;
    if (m_boot) return e;
    if (m_wait >= 0) begin
      e.io_req = 1'b1;
      if (rdy) begin
        e.s_datos = 1'b1;
        e.we3     = 1'b1;
        e.stall   = 1'b0;
      end else if (m_wait == TO) begin
        e.stall = 1'b0;
      end
      return e;
    end
    e.stall = 1'b0;
    case (op)
      OP_J:   e.s_inc = 1'b0;
      OP_JZ:  e.s_inc = ~zz;
      OP_JNZ: e.s_inc = zz;
      OP_IN: begin
        e.stall  = 1'b1;
        e.io_req = 1'b1;
      end
      default: begin
        e.s_inm  = op[5];
        e.op_alu = op[4:2];
        e.we3    = 1'b1;
        e.wez    = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic step(input logic [5:0] op, input logic zz, input logic rdy, input logic rst);
    outv_t e;
    @(posedge clk);
    #1;
    opcode   = op;
    z        = zz;
    io_ready = rdy;
    reset    = rst;
    #3;
    e = model_out(opcode, z, io_ready);
    vectors++;
    if (dut_v !== e) begin
      miscompares++;
      $display("FAIL model t=%0t op=%b z=%b rdy=%b rst=%b: got %03h expected %03h",
               $time, opcode, z, io_ready, reset, dut_v, e);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic [5:0] rop;
    opcode   = 6'd0;
    z        = 1'b0;
    io_ready = 1'b0;
    #1 reset = 1'b1;

    step(6'd0, 1'b0, 1'b0, 1'b1);
    step(6'd0, 1'b0, 1'b1, 1'b1);
    chk1("rst_stall", stall, 1'b1);
    chk1("rst_io_req", io_req, 1'b0);
    chk1("rst_s_inc", s_inc, 1'b1);
    chk1("rst_io_err", io_err, 1'b0);

    step(6'b101000, 1'b0, 1'b0, 1'b0);
    chk1("boot_stall", stall, 1'b1);
    chk1("boot_we3", we3, 1'b0);
    step(6'b101000, 1'b0, 1'b0, 1'b0);
    chk1("alu_s_inm", s_inm, 1'b1);
    chk3("alu_op_alu", op_alu, 3'b010);
    chk1("alu_we3", we3, 1'b1);
    chk1("alu_wez", wez, 1'b1);
    chk1("alu_stall", stall, 1'b0);

    step(OP_JZ, 1'b1, 1'b0, 1'b0);
    chk1("jz_taken_s_inc", s_inc, 1'b0);
    chk1("jz_taken_we3", we3, 1'b0);
    step(OP_JZ, 1'b0, 1'b1, 1'b0);
    chk1("jz_fall_s_inc", s_inc, 1'b1);
    chk1("jz_fall_we3", we3, 1'b0);
    step(OP_JNZ, 1'b1, 1'b0, 1'b0);
    step(OP_J, 1'b0, 1'b0, 1'b0);
    chk1("j_s_inc", s_inc, 1'b0);

    // Data on third IOWAIT cycle
    step(OP_IN, 1'b0, 1'b0, 1'b0);
    chk1("in_req_stall", stall, 1'b1);
    chk1("in_req_io_req", io_req, 1'b1);
    step(OP_J, 1'b0, 1'b0, 1'b0);
    chk1("iow1_stall", stall, 1'b1);
    step(OP_J, 1'b0, 1'b0, 1'b0);
    chk1("iow2_stall", stall, 1'b1);
    step(OP_J, 1'b0, 1'b1, 1'b0);
    chk1("iow3_s_datos", s_datos, 1'b1);
    chk1("iow3_we3", we3, 1'b1);
    chk1("iow3_stall", stall, 1'b0);
    chk1("iow3_wez", wez, 1'b0);

    // Data exactly in the timeout cycle
    step(OP_IN, 1'b0, 1'b0, 1'b0);
    repeat (TO) step(6'b000000, 1'b0, 1'b0, 1'b0);
    chk1("pre_to_stall", stall, 1'b1);
    step(6'b000000, 1'b0, 1'b1, 1'b0);
    chk1("to_rdy_we3", we3, 1'b1);
    chk1("to_rdy_s_datos", s_datos, 1'b1);
    step(6'b001100, 1'b0, 1'b0, 1'b0);
    chk1("to_rdy_io_err", io_err, 1'b0);

    // Genuine timeout
    step(OP_IN, 1'b0, 1'b0, 1'b0);
    repeat (TO) step(6'b000000, 1'b0, 1'b0, 1'b0);
    step(6'b000000, 1'b0, 1'b0, 1'b0);
    chk1("to_stall", stall, 1'b0);
    chk1("to_we3", we3, 1'b0);
    chk1("to_s_inc", s_inc, 1'b1);
    step(6'b000000, 1'b0, 1'b0, 1'b0);
    chk1("to_io_err", io_err, 1'b1);
    chk1("to_run_we3", we3, 1'b1);

    // Back-to-back IN
    step(OP_IN, 1'b0, 1'b0, 1'b0);
    step(OP_IN, 1'b0, 1'b1, 1'b0);
    chk1("b2b_first_we3", we3, 1'b1);
    step(OP_IN, 1'b0, 1'b0, 1'b0);
    chk1("b2b_second_io_req", io_req, 1'b1);
    chk1("b2b_second_stall", stall, 1'b1);
    step(6'b000000, 1'b0, 1'b1, 1'b0);
    chk1("b2b_second_we3", we3, 1'b1);
    chk1("err_sticky", io_err, 1'b1);

    // Reset in the second IOWAIT cycle
    step(OP_IN, 1'b0, 1'b0, 1'b0);
    step(6'b000000, 1'b0, 1'b0, 1'b0);
    step(6'b000000, 1'b0, 1'b1, 1'b1);
    chk1("rst_iow_io_req", io_req, 1'b0);
    chk1("rst_iow_we3", we3, 1'b0);
    chk1("rst_iow_stall", stall, 1'b1);
    chk1("rst_iow_io_err", io_err, 1'b0);
    step(OP_IN, 1'b0, 1'b1, 1'b0);
    chk1("post_rst_boot_io_req", io_req, 1'b0);
    chk1("post_rst_boot_we3", we3, 1'b0);

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 7))
        0: rop = OP_J;
        1: rop = OP_JZ;
        2: rop = OP_JNZ;
        3: rop = OP_IN;
        default: rop = 6'($urandom);
      endcase
      step(rop, 1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
